// File: rtl/mmc_spi_pkg.sv
// Shared types and constants for the SPI-mode MMC/SD host controller.
package mmc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [7:0]  FILL_BYTE     = 8'hFF;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BIT_CNT_W     = $clog2(BITS_PER_BYTE);

    // Per-command attributes captured at accept time.
    typedef struct packed {
        logic hunt;
        logic fast;
    } mmc_cmd_t;

endpackage

// File: rtl/mmc_spi_if.sv
// Byte command / response bus between the disk logic and the MMC SPI host.
interface mmc_spi_if;

    logic       cs_assert;
    logic       fast;
    logic       cmd_valid;
    logic       cmd_hunt;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;

    modport master (
        output cs_assert, fast, cmd_valid, cmd_hunt, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );

    modport slave (
        input  cs_assert, fast, cmd_valid, cmd_hunt, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );

endinterface

// File: rtl/mmc_spi_clkgen.sv
// Loadable down-counter timing each mmc_sclk half-period; phase_end_c marks its last cycle.
module mmc_spi_clkgen #(
    parameter int unsigned SLOW_DIV = 63,
    parameter int unsigned FAST_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    input  logic fast_sel,
    output logic phase_end_c
);
    localparam int unsigned MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int unsigned CNT_W   = (MAX_DIV > 0) ? $clog2(MAX_DIV + 1) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload_c;

    assign reload_c    = fast_sel ? CNT_W'(FAST_DIV) : CNT_W'(SLOW_DIV);
    assign phase_end_c = en && (cnt == '0);

    // Reload on command accept and at every phase boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload_c;
        end else if (en) begin
            cnt <= (cnt == '0) ? reload_c : cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mmc_spi_master.sv
// SPI mode-0 byte engine for MMC/SD cards, with optional hunt for a non-0xFF response.
module mmc_spi_master
    import mmc_spi_pkg::*;
#(
    parameter int unsigned SLOW_DIV = 63,
    parameter int unsigned FAST_DIV = 1,
    parameter int unsigned MAX_POLL = 8
) (
    input  logic     clk,
    input  logic     reset,
    mmc_spi_if.slave bus,
    output logic     mmc_cs,
    output logic     mmc_sclk,
    output logic     mmc_do,
    input  logic     mmc_di
);
    localparam int unsigned          POLL_W   = $clog2(MAX_POLL + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_BYTE - 1);

    state_t               state;
    mmc_cmd_t             cmd_q;
    logic [7:0]           shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [POLL_W-1:0]    poll_cnt;
    logic                 sample_pend;

    logic       accept_c;
    logic       fast_sel_c;
    logic       phase_end_c;
    logic       more_polls_c;
    logic [7:0] rx_next_c;

    assign accept_c   = (state == IDLE) && bus.cmd_valid && bus.cmd_ready;
    assign fast_sel_c = (state == IDLE) ? bus.fast : cmd_q.fast;
    // With a one-cycle half-period the sample and the phase end share an edge.
    assign rx_next_c  = sample_pend ? {shreg[6:0], mmc_di} : shreg;
    assign more_polls_c = cmd_q.hunt && (rx_next_c == FILL_BYTE)
                       && ((32'(poll_cnt) + 32'd1) < MAX_POLL);

    mmc_spi_clkgen #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV)
    ) u_clkgen (
        .clk         (clk),
        .reset       (reset),
        .load        (accept_c),
        .en          (state != IDLE),
        .fast_sel    (fast_sel_c),
        .phase_end_c (phase_end_c)
    );

    // Shift register is shared: MSB drives mmc_do, mmc_di enters at the LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cmd_q           <= '0;
            shreg           <= FILL_BYTE;
            bit_cnt         <= '0;
            poll_cnt        <= '0;
            sample_pend     <= 1'b0;
            mmc_cs          <= 1'b1;
            mmc_sclk        <= 1'b0;
            mmc_do          <= 1'b1;
            bus.cmd_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= FILL_BYTE;
            bus.rsp_timeout <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    mmc_cs        <= ~bus.cs_assert;
                    if (accept_c) begin
                        cmd_q         <= '{hunt: bus.cmd_hunt, fast: bus.fast};
                        shreg         <= bus.cmd_data;
                        mmc_do        <= bus.cmd_data[7];
                        bit_cnt       <= '0;
                        poll_cnt      <= '0;
                        bus.cmd_ready <= 1'b0;
                        state         <= LOW;
                    end
                end
                LOW: begin
                    if (phase_end_c) begin
                        mmc_sclk    <= 1'b1;
                        sample_pend <= 1'b1;
                        state       <= HIGH;
                    end
                end
                HIGH: begin
                    if (sample_pend) begin
                        shreg       <= rx_next_c;
                        sample_pend <= 1'b0;
                    end
                    if (phase_end_c) begin
                        mmc_sclk <= 1'b0;
                        if (bit_cnt != LAST_BIT) begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            mmc_do  <= rx_next_c[7];
                            state   <= LOW;
                        end else if (more_polls_c) begin
                            shreg    <= FILL_BYTE;
                            mmc_do   <= 1'b1;
                            bit_cnt  <= '0;
                            poll_cnt <= poll_cnt + POLL_W'(1);
                            state    <= LOW;
                        end else begin
                            mmc_do          <= 1'b1;
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_data    <= rx_next_c;
                            bus.rsp_timeout <= cmd_q.hunt && (rx_next_c == FILL_BYTE);
                            bus.cmd_ready   <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmc_spi_master.sv
// Self-checking bench for mmc_spi_master: SPI slave model plus byte-level reference model.
module tb_mmc_spi_master;

    localparam int unsigned SLOW_DIV = 63;
    localparam int unsigned FAST_DIV = 1;
    localparam int unsigned MAX_POLL = 8;

    logic clk = 1'b0;
    logic reset;
    logic mmc_cs, mmc_sclk, mmc_do, mmc_di;

    mmc_spi_if bus();

    mmc_spi_master #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV),
        .MAX_POLL (MAX_POLL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .mmc_cs   (mmc_cs),
        .mmc_sclk (mmc_sclk),
        .mmc_do   (mmc_do),
        .mmc_di   (mmc_di)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // SPI slave: byte stream shifted out MSB first, advancing on each sclk falling edge.
    logic [7:0]   slv_b [0:15];
    logic [127:0] slv_bits = '1;
    int           rise_cnt = 0;
    int           fall_cnt = 0;
    int           miso_base = 0;
    int           miso_idx;
    logic         mosi_log [0:4095];

    assign miso_idx = fall_cnt - miso_base;
    assign mmc_di   = (miso_idx >= 0 && miso_idx < 128) ? slv_bits[7'(127 - miso_idx)] : 1'b1;

    always @(posedge mmc_sclk) begin
        mosi_log[rise_cnt % 4096] = mmc_do;
        rise_cnt = rise_cnt + 1;
    end

    always @(negedge mmc_sclk) fall_cnt = fall_cnt + 1;

    // Measurements from the most recent command.
    int         m_lat, m_runs, m_bad, m_rise0, m_nrise;
    logic       m_cs_chg, m_rdy_t1, m_do_t1, m_rv_after, m_rdy_after, m_to;
    logic [7:0] m_rsp;

    task automatic pack_slave();
        for (int i = 0; i < 16; i++) slv_bits[127 - 8*i -: 8] = slv_b[i];
    endtask

    // Reference: bytes clocked, final response and timeout from the slave's byte list.
    task automatic model(input logic hunt, output int nb, output logic [7:0] r, output logic to);
        nb = 0;
        do begin
            r  = slv_b[nb];
            nb = nb + 1;
        end while (hunt && r == 8'hFF && nb < int'(MAX_POLL));
        to = hunt && (r == 8'hFF);
    endtask

    function automatic logic [7:0] mosi_byte(input int j);
        logic [7:0] b = '0;
        for (int k = 0; k < 8; k++) b = {b[6:0], mosi_log[(m_rise0 + 8*j + k) % 4096]};
        return b;
    endfunction

    // Issue one command and observe it until rsp_valid or the cycle budget runs out.
    task automatic run_cmd(input logic [7:0] data, input logic hunt, input logic f,
                           input int h, input int budget, input logic toggle_cs);
        logic prev;
        int   run;
        @(negedge clk);
        bus.cmd_data  = data;
        bus.cmd_hunt  = hunt;
        bus.fast      = f;
        bus.cmd_valid = 1'b1;
        m_rise0   = rise_cnt;
        miso_base = fall_cnt;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = $urandom_range(255, 0);
        bus.cmd_hunt  = ~hunt;
        bus.fast      = ~f;
        m_rdy_t1 = bus.cmd_ready;
        m_do_t1  = mmc_do;
        m_cs_chg = 1'b0;
        m_lat = -1; m_runs = 0; m_bad = 0;
        prev = mmc_sclk; run = 1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (toggle_cs && (c == 200 || c == 600)) bus.cs_assert = ~bus.cs_assert;
            if (mmc_sclk === prev) run++;
            else begin
                m_runs++;
                if (run != h) m_bad++;
                run = 1; prev = mmc_sclk;
            end
            if (mmc_cs !== 1'b0) m_cs_chg = 1'b1;
            if (bus.rsp_valid === 1'b1) begin
                m_lat = c;
                break;
            end
        end
        m_rsp   = bus.rsp_data;
        m_to    = bus.rsp_timeout;
        m_nrise = rise_cnt - m_rise0;
        @(posedge clk); #1;
        m_rv_after  = bus.rsp_valid;
        m_rdy_after = bus.cmd_ready;
        bus.fast     = 1'b1;
        bus.cmd_hunt = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cs_assert = 1'b0; bus.fast = 1'b0; bus.cmd_valid = 1'b0;
        bus.cmd_hunt = 1'b0; bus.cmd_data = 8'h00;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (mmc_cs !== 1'b1) $display("FAIL reset_cs: got %b want 1", mmc_cs); else n_pass++;
        n_checks++; if (mmc_sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", mmc_sclk); else n_pass++;
        n_checks++; if (mmc_do !== 1'b1) $display("FAIL reset_do: got %b want 1", mmc_do); else n_pass++;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_data !== 8'hFF) $display("FAIL reset_rsp_data: got %h want ff", bus.rsp_data); else n_pass++;
        n_checks++; if (bus.rsp_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.rsp_timeout); else n_pass++;
        @(negedge clk) reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (mmc_cs !== 1'b1) $display("FAIL idle_cs_deselected: got %b want 1", mmc_cs); else n_pass++;
    endtask

    task automatic test_basic();
        bus.cs_assert = 1'b1;
        slv_b[0] = 8'hA5;
        pack_slave();
        repeat (2) @(posedge clk);
        run_cmd(8'h40, 1'b0, 1'b1, FAST_DIV + 1, 200, 1'b0);
        n_checks++; if (m_rdy_t1 !== 1'b0) $display("FAIL basic_ready_t1: got %b want 0", m_rdy_t1); else n_pass++;
        n_checks++; if (m_do_t1 !== 1'b0) $display("FAIL basic_do_bit7: got %b want 0", m_do_t1); else n_pass++;
        n_checks++; if (m_lat != 32) $display("FAIL basic_latency: got %0d want 32", m_lat); else n_pass++;
        n_checks++; if (m_rsp !== 8'hA5) $display("FAIL basic_rsp: got %h want a5", m_rsp); else n_pass++;
        n_checks++; if (m_to !== 1'b0) $display("FAIL basic_timeout: got %b want 0", m_to); else n_pass++;
        n_checks++; if (m_nrise != 8) $display("FAIL basic_rises: got %0d want 8", m_nrise); else n_pass++;
        n_checks++; if (mosi_byte(0) !== 8'h40) $display("FAIL basic_mosi: got %h want 40", mosi_byte(0)); else n_pass++;
        n_checks++; if (m_cs_chg !== 1'b0) $display("FAIL basic_cs_low: got %b want 0", m_cs_chg); else n_pass++;
        n_checks++; if (m_bad != 0 || m_runs != 16) $display("FAIL basic_phases: got %0d bad of %0d want 0 of 16", m_bad, m_runs); else n_pass++;
        n_checks++; if (m_rv_after !== 1'b0) $display("FAIL basic_pulse_width: got %b want 0", m_rv_after); else n_pass++;
        n_checks++; if (m_rdy_after !== 1'b1) $display("FAIL basic_ready_after: got %b want 1", m_rdy_after); else n_pass++;
    endtask

    task automatic test_slow();
        logic [7:0] r = 8'($urandom_range(255, 0));
        slv_b[0] = r;
        pack_slave();
        run_cmd(8'hFF, 1'b0, 1'b0, SLOW_DIV + 1, 1200, 1'b1);
        n_checks++; if (m_lat != 1024) $display("FAIL slow_latency: got %0d want 1024", m_lat); else n_pass++;
        n_checks++; if (m_bad != 0 || m_runs != 16) $display("FAIL slow_phases: got %0d bad of %0d want 0 of 16", m_bad, m_runs); else n_pass++;
        n_checks++; if (m_cs_chg !== 1'b0) $display("FAIL slow_cs_held: got %b want 0", m_cs_chg); else n_pass++;
        n_checks++; if (m_rsp !== r) $display("FAIL slow_rsp: got %h want %h", m_rsp, r); else n_pass++;
        n_checks++; if (mosi_byte(0) !== 8'hFF) $display("FAIL slow_mosi: got %h want ff", mosi_byte(0)); else n_pass++;
    endtask

    task automatic test_hunt();
        logic [7:0] c = 8'($urandom_range(255, 0));
        int bad = 0;
        slv_b[0] = 8'hFF; slv_b[1] = 8'hFF; slv_b[2] = 8'h01;
        pack_slave();
        run_cmd(c, 1'b1, 1'b1, FAST_DIV + 1, 300, 1'b0);
        for (int j = 1; j < 3; j++) if (mosi_byte(j) !== 8'hFF) bad++;
        n_checks++; if (m_nrise != 24) $display("FAIL hunt_rises: got %0d want 24", m_nrise); else n_pass++;
        n_checks++; if (m_bad != 0 || m_runs != 48) $display("FAIL hunt_continuous: got %0d bad of %0d want 0 of 48", m_bad, m_runs); else n_pass++;
        n_checks++; if (mosi_byte(0) !== c) $display("FAIL hunt_mosi_cmd: got %h want %h", mosi_byte(0), c); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL hunt_mosi_fill: got %0d non-ff bytes want 0", bad); else n_pass++;
        n_checks++; if (m_lat != 96) $display("FAIL hunt_latency: got %0d want 96", m_lat); else n_pass++;
        n_checks++; if (m_rsp !== 8'h01 || m_to !== 1'b0) $display("FAIL hunt_rsp: got %h/%b want 01/0", m_rsp, m_to); else n_pass++;
    endtask

    task automatic test_hunt_timeout();
        for (int i = 0; i < 16; i++) slv_b[i] = 8'hFF;
        pack_slave();
        run_cmd(8'hFF, 1'b1, 1'b1, FAST_DIV + 1, 600, 1'b0);
        n_checks++; if (m_nrise != 64) $display("FAIL timeout_rises: got %0d want 64", m_nrise); else n_pass++;
        n_checks++; if (m_lat != 256) $display("FAIL timeout_latency: got %0d want 256", m_lat); else n_pass++;
        n_checks++; if (m_rsp !== 8'hFF || m_to !== 1'b1) $display("FAIL timeout_rsp: got %h/%b want ff/1", m_rsp, m_to); else n_pass++;
        repeat (20) @(posedge clk); #1;
        n_checks++; if (rise_cnt - m_rise0 != 64) $display("FAIL timeout_stopped: got %0d want 64", rise_cnt - m_rise0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int r0, pulses = 0;
        slv_b[0] = 8'h3C;
        pack_slave();
        @(negedge clk);
        bus.cmd_data = 8'h95; bus.cmd_hunt = 1'b1; bus.fast = 1'b1; bus.cmd_valid = 1'b1;
        r0 = rise_cnt;
        miso_base = fall_cnt;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 200 && rise_cnt < r0 + 3; c++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (rise_cnt - r0 != 3) $display("FAIL rstmid_reach3: got %0d want 3", rise_cnt - r0); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({mmc_cs, mmc_sclk, mmc_do} !== 3'b101) $display("FAIL rstmid_pins: got %b want 101", {mmc_cs, mmc_sclk, mmc_do}); else n_pass++;
        n_checks++; if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout} !== 3'b100) $display("FAIL rstmid_flags: got %b want 100", {bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout}); else n_pass++;
        n_checks++; if (bus.rsp_data !== 8'hFF) $display("FAIL rstmid_rsp_data: got %h want ff", bus.rsp_data); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) $display("FAIL rstmid_no_rsp: got %0d pulses want 0", pulses); else n_pass++;
        run_cmd(8'h95, 1'b0, 1'b1, FAST_DIV + 1, 200, 1'b0);
        n_checks++; if (m_rsp !== 8'h3C || m_lat != 32) $display("FAIL rstmid_next: got %h lat %0d want 3c lat 32", m_rsp, m_lat); else n_pass++;
        n_checks++; if (mosi_byte(0) !== 8'h95) $display("FAIL rstmid_mosi: got %h want 95", mosi_byte(0)); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] c, er;
        logic       hunt, eto;
        int         nb, bad;
        for (int it = 0; it < 8; it++) begin
            c    = 8'($urandom_range(255, 0));
            hunt = 1'($urandom_range(1, 0));
            for (int i = 0; i < 16; i++)
                slv_b[i] = ($urandom_range(2, 0) != 0) ? 8'hFF : 8'($urandom_range(255, 0));
            pack_slave();
            model(hunt, nb, er, eto);
            run_cmd(c, hunt, 1'b1, FAST_DIV + 1, 32 * nb + 50, 1'b0);
            bad = 0;
            for (int j = 1; j < nb; j++) if (mosi_byte(j) !== 8'hFF) bad++;
            n_checks++; if (m_rsp !== er || m_to !== eto) $display("FAIL rand%0d_rsp: got %h/%b want %h/%b", it, m_rsp, m_to, er, eto); else n_pass++;
            n_checks++; if (m_lat != 32 * nb || m_nrise != 8 * nb) $display("FAIL rand%0d_len: got lat %0d rises %0d want %0d/%0d", it, m_lat, m_nrise, 32 * nb, 8 * nb); else n_pass++;
            n_checks++; if (mosi_byte(0) !== c || bad != 0) $display("FAIL rand%0d_mosi: got %h (%0d bad fill) want %h", it, mosi_byte(0), bad, c); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow();
        test_hunt();
        test_reset_mid();
        test_hunt_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
